// File: rtl/spike_winner_decoder.sv
// Decodes one pattern window of network output spikes into the winning neuron,
// its spike count and a saturation flag, delivered over a valid/ready handshake.
module spike_winner_decoder #(
  parameter int p_n      = 8,
  parameter int p_window = 100,
  parameter int p_cnt_w  = 8,
  parameter int p_idx_w  = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [p_n:1]       i_spike,
  input  logic               i_pattern_start,
  input  logic               i_endof_epochs,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [p_idx_w-1:0] o_winner,
  output logic [p_cnt_w-1:0] o_count,
  output logic               o_saturated,
  output logic               o_infer,
  output logic               o_missed
);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_RESOLVE, S_HOLD} state_e;

  localparam int                 c_tmr_w   = $clog2(p_window + 1);
  localparam logic [c_tmr_w-1:0] c_tmr_end = c_tmr_w'(p_window);
  localparam logic [p_idx_w-1:0] c_idx_end = p_idx_w'(p_n);
  localparam logic [p_cnt_w-1:0] c_cnt_max = '1;

  state_e               state_q, state_d;
  logic [p_cnt_w-1:0]   cnt_q [p_n];
  logic [p_cnt_w-1:0]   cnt_d [p_n];
  logic                 sat_q, sat_d;
  logic [c_tmr_w-1:0]   tmr_q, tmr_d;
  logic [p_idx_w-1:0]   rsv_idx_q, rsv_idx_d;
  logic [p_idx_w-1:0]   best_idx_q, best_idx_d;
  logic [p_cnt_w-1:0]   best_cnt_q, best_cnt_d;
  logic [p_idx_w-1:0]   winner_q, winner_d;
  logic [p_cnt_w-1:0]   count_q, count_d;
  logic                 saturated_q, saturated_d;
  logic                 infer_q, infer_d;
  logic                 missed_q, missed_d;

  logic                 handshake, start_win, last_count, last_resolve, better;
  logic [p_cnt_w-1:0]   cur_cnt, cand_cnt;
  logic [p_idx_w-1:0]   cand_idx;

  // A start is honoured when idle, mid-window (restart) or on the accepting HOLD cycle.
  always_comb begin
    handshake    = (state_q == S_HOLD) && i_ready;
    start_win    = i_pattern_start &&
                   ((state_q == S_IDLE) || (state_q == S_COUNT) || handshake);
    last_count   = (state_q == S_COUNT) && (tmr_q == c_tmr_end);
    last_resolve = (state_q == S_RESOLVE) && (rsv_idx_q == c_idx_end);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of process ordering.
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start_win) state_d = S_COUNT;
      S_COUNT:   if (!start_win && last_count) state_d = S_RESOLVE;
      S_RESOLVE: if (last_resolve) state_d = S_HOLD;
      S_HOLD:    if (start_win) state_d = S_COUNT;
                 else if (handshake) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_valid = (state_q == S_HOLD);
  end

  // Per-neuron saturating counters; a start clears and adds the coincident spikes.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cnt_d = cnt_q;
    sat_d = sat_q;
    tmr_d = tmr_q;
    if (start_win) begin
      sat_d = 1'b0;
      tmr_d = c_tmr_w'(1);
      for (int i = 0; i < p_n; i++) cnt_d[i] = p_cnt_w'(i_spike[i+1]);
    end else if (state_q == S_COUNT) begin
      tmr_d = tmr_q + c_tmr_w'(1);
      for (int i = 0; i < p_n; i++) begin
        if (i_spike[i+1]) begin
          if (cnt_q[i] == c_cnt_max) sat_d = 1'b1;
          else cnt_d[i] = cnt_q[i] + p_cnt_w'(1);
        end
      end
    end
  end

  always_comb begin
    cur_cnt = '0;
    for (int i = 0; i < p_n; i++) begin
      if (rsv_idx_q == p_idx_w'(i + 1)) cur_cnt = cnt_q[i];
    end
    // Strict compare keeps the lowest index on a tie.
    better   = (state_q == S_RESOLVE) && (cur_cnt > best_cnt_q);
    cand_idx = better ? rsv_idx_q : best_idx_q;
    cand_cnt = better ? cur_cnt : best_cnt_q;
  end

  always_comb begin
    rsv_idx_d   = rsv_idx_q;
    best_idx_d  = best_idx_q;
    best_cnt_d  = best_cnt_q;
    winner_d    = winner_q;
    count_d     = count_q;
    saturated_d = saturated_q;
    if ((state_q == S_COUNT) && (state_d == S_RESOLVE)) begin
      rsv_idx_d  = p_idx_w'(1);
      best_idx_d = '0;
      best_cnt_d = '0;
    end else if (state_q == S_RESOLVE) begin
      rsv_idx_d  = rsv_idx_q + p_idx_w'(1);
      best_idx_d = cand_idx;
      best_cnt_d = cand_cnt;
      if (last_resolve) begin
        winner_d    = cand_idx;
        count_d     = cand_cnt;
        saturated_d = sat_q;
      end
    end
    infer_d  = start_win ? i_endof_epochs : infer_q;
    missed_d = i_pattern_start && (state_q != S_IDLE) && !handshake;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the counter array is reset like any other register; it is small
      // flop storage, not a RAM, and must read zero straight out of reset.
      cnt_q       <= '{default: '0};
      sat_q       <= 1'b0;
      tmr_q       <= '0;
      rsv_idx_q   <= '0;
      best_idx_q  <= '0;
      best_cnt_q  <= '0;
      winner_q    <= '0;
      count_q     <= '0;
      saturated_q <= 1'b0;
      infer_q     <= 1'b0;
      missed_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      tmr_q       <= tmr_d;
      rsv_idx_q   <= rsv_idx_d;
      best_idx_q  <= best_idx_d;
      best_cnt_q  <= best_cnt_d;
      winner_q    <= winner_d;
      count_q     <= count_d;
      saturated_q <= saturated_d;
      infer_q     <= infer_d;
      missed_q    <= missed_d;
    end
  end

  assign o_winner    = winner_q;
  assign o_count     = count_q;
  assign o_saturated = saturated_q;
  assign o_infer     = infer_q;
  assign o_missed    = missed_q;

endmodule

// File: tb/tb_spike_winner_decoder.sv
// Scoreboard bench for spike_winner_decoder: expected results are modelled from the
// driven spikes, queued per window and compared when the decoder presents them.
module tb_spike_winner_decoder;

  typedef struct {
    logic [3:0] w;
    logic [5:0] c;
    logic       s;
    logic       inf;
  } res_t;

  logic       clk;
  logic       rst_n;
  logic [8:1] spike;
  logic       pattern_start;
  logic       endof_epochs;
  logic       ready;
  logic       valid;
  logic [3:0] winner;
  logic [5:0] count;
  logic       saturated;
  logic       infer;
  logic       missed;

  int   checks = 0;
  int   errors = 0;
  int   rel    = 0;
  int   exp_cnt [1:8];
  logic exp_inf;
  res_t exp_r;
  res_t sb [$];

  spike_winner_decoder #(
    .p_n     (8),
    .p_window(100),
    .p_cnt_w (6),
    .p_idx_w (4)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_spike        (spike),
    .i_pattern_start(pattern_start),
    .i_endof_epochs (endof_epochs),
    .i_ready        (ready),
    .o_valid        (valid),
    .o_winner       (winner),
    .o_count        (count),
    .o_saturated    (saturated),
    .o_infer        (infer),
    .o_missed       (missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic [8:1] s, input logic st);
    spike = s;
    pattern_start = st;
    @(posedge clk);
    #1;
    spike = '0;
    pattern_start = 1'b0;
    rel++;
  endtask

  task automatic count_step(input logic [8:1] s);
    for (int n = 1; n <= 8; n++) if (s[n]) exp_cnt[n]++;
    step(s, 1'b0);
  endtask

  task automatic begin_window(input logic inf, input logic [8:1] s);
    for (int n = 1; n <= 8; n++) exp_cnt[n] = s[n] ? 1 : 0;
    exp_inf = inf;
    endof_epochs = inf;
    rel = 0;
    step(s, 1'b1);
  endtask

  function automatic void push_expected();
    res_t r;
    int   best = 0;
    int   bi = 0;
    logic sat = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      int c;
      c = (exp_cnt[n] > 63) ? 63 : exp_cnt[n];
      if (exp_cnt[n] > 63) sat = 1'b1;
      if (c > best) begin
        best = c;
        bi = n;
      end
    end
    r.w = 4'(bi);
    r.c = 6'(best);
    r.s = sat;
    r.inf = exp_inf;
    sb.push_back(r);
  endfunction

  task automatic collect(input string name, input logic [8:1] wait_spk);
    int n = 0;
    while (valid !== 1'b1 && n < 300) begin
      step(wait_spk, 1'b0);
      n++;
    end
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: o_valid=%b required 1", name, valid);
      return;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected result: winner=%0d with empty scoreboard", name, winner);
      return;
    end
    exp_r = sb.pop_front();
    checks++;
    if (rel !== 109) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles required 109", name, rel);
    end
    checks++;
    if (winner !== exp_r.w) begin
      errors++;
      $display("FAIL %s winner: got %0d required %0d", name, winner, exp_r.w);
    end
    checks++;
    if (count !== exp_r.c) begin
      errors++;
      $display("FAIL %s count: got %0d required %0d", name, count, exp_r.c);
    end
    checks++;
    if (saturated !== exp_r.s) begin
      errors++;
      $display("FAIL %s saturated: got %b required %b", name, saturated, exp_r.s);
    end
    checks++;
    if (infer !== exp_r.inf) begin
      errors++;
      $display("FAIL %s infer: got %b required %b", name, infer, exp_r.inf);
    end
    if (ready) begin
      step('0, 1'b0);
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL %s release: o_valid=%b required 0 after handshake", name, valid);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (valid !== 1'b0 || winner !== 4'd0 || count !== 6'd0 || saturated !== 1'b0 ||
        infer !== 1'b0 || missed !== 1'b0) begin
      errors++;
      $display("FAIL %s: valid=%b winner=%0d count=%0d sat=%b infer=%b missed=%b required all 0",
               name, valid, winner, count, saturated, infer, missed);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    spike = '0;
    pattern_start = 1'b0;
    endof_epochs = 1'b0;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    step('0, 1'b0);
  endtask

  task automatic test_single_winner();
    logic [8:1] s;
    ready = 1'b1;
    step(8'hFF, 1'b0);
    step(8'hFF, 1'b0);
    begin_window(1'b0, '0);
    for (int c = 1; c <= 100; c++) begin
      s = '0;
      if (c % 5 == 0 && c <= 25) s[3] = 1'b1;
      if (c == 30 || c == 60) s[6] = 1'b1;
      count_step(s);
    end
    push_expected();
    collect("single_winner", '0);
  endtask

  task automatic test_reset_mid_window();
    logic [8:1] s;
    ready = 1'b1;
    begin_window(1'b1, '0);
    for (int c = 1; c <= 30; c++) count_step(8'h01);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_window");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step('0, 1'b0);
    check_all_zero("after_reset_release");
    begin_window(1'b0, '0);
    for (int c = 1; c <= 100; c++) begin
      s = '0;
      if (c == 11 || c == 22 || c == 33) s[5] = 1'b1;
      count_step(s);
    end
    push_expected();
    collect("clean_after_reset", '0);
  endtask

  task automatic test_tie_silence();
    logic [8:1] s;
    ready = 1'b1;
    begin_window(1'b0, 8'b0100_0000);
    for (int c = 1; c <= 100; c++) begin
      s = '0;
      if (c == 3 || c == 5 || c == 7) s[7] = 1'b1;
      if (c == 10 || c == 20 || c == 30 || c == 40) s[2] = 1'b1;
      count_step(s);
    end
    push_expected();
    collect("tie", 8'h01);
    begin_window(1'b0, '0);
    for (int c = 1; c <= 100; c++) count_step('0);
    push_expected();
    collect("silence", '0);
  endtask

  task automatic test_saturation();
    ready = 1'b1;
    begin_window(1'b0, 8'h80);
    for (int c = 1; c <= 100; c++) count_step(8'h80);
    push_expected();
    collect("saturation", '0);
  endtask

  task automatic test_backpressure();
    logic [8:1] s;
    logic       exp_m;
    ready = 1'b0;
    begin_window(1'b0, '0);
    for (int c = 1; c <= 100; c++) begin
      s = '0;
      if (c % 10 == 0 && c <= 70) s[4] = 1'b1;
      count_step(s);
    end
    push_expected();
    collect("backpressure", '0);
    for (int k = 0; k < 20; k++) begin
      step(8'hFF, k == 10);
      checks++;
      if (valid !== 1'b1 || winner !== exp_r.w || count !== exp_r.c ||
          saturated !== exp_r.s || infer !== exp_r.inf) begin
        errors++;
        $display("FAIL hold_stable k=%0d: valid=%b winner=%0d count=%0d sat=%b infer=%b required 1/%0d/%0d/%b/%b",
                 k, valid, winner, count, saturated, infer, exp_r.w, exp_r.c, exp_r.s, exp_r.inf);
      end
      exp_m = (k == 10);
      checks++;
      if (missed !== exp_m) begin
        errors++;
        $display("FAIL hold_missed k=%0d: o_missed=%b required %b", k, missed, exp_m);
      end
    end
    ready = 1'b1;
    begin_window(1'b1, '0);
    ready = 1'b0;
    checks++;
    if (valid !== 1'b0 || missed !== 1'b0) begin
      errors++;
      $display("FAIL handshake_start: valid=%b missed=%b required 0/0", valid, missed);
    end
    endof_epochs = 1'b0;
    ready = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      s = '0;
      if (c == 50 || c == 51) s[1] = 1'b1;
      count_step(s);
    end
    push_expected();
    collect("handshake_start_window", '0);
  endtask

  task automatic test_restart_epoch();
    logic [8:1] s;
    ready = 1'b1;
    begin_window(1'b0, '0);
    for (int c = 1; c <= 39; c++) count_step(8'h01);
    checks++;
    if (missed !== 1'b0) begin
      errors++;
      $display("FAIL restart_pre: o_missed=%b required 0", missed);
    end
    begin_window(1'b1, 8'b0010_0000);
    endof_epochs = 1'b0;
    checks++;
    if (missed !== 1'b1) begin
      errors++;
      $display("FAIL restart_missed: o_missed=%b required 1", missed);
    end
    for (int c = 1; c <= 100; c++) begin
      s = '0;
      if (c == 20 || c == 40) s[6] = 1'b1;
      if (c == 5 || c == 6) s[1] = 1'b1;
      count_step(s);
      if (c == 1) begin
        checks++;
        if (missed !== 1'b0) begin
          errors++;
          $display("FAIL restart_missed_pulse: o_missed=%b required 0", missed);
        end
      end
    end
    push_expected();
    collect("restart_epoch", '0);
  endtask

  initial begin
    test_reset();
    test_single_winner();
    test_reset_mid_window();
    test_tie_silence();
    test_saturation();
    test_backpressure();
    test_restart_epoch();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d results never produced", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
